// File: rtl/pixel_unpacker_pkg.sv
// pixel_unpacker_pkg: shared FSM state type, beat width and last-index helpers for pixel_unpacker
package pixel_unpacker_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, DONE} state_t;
  localparam int DEFAULT_PPB = 4;
  localparam int BEAT_W = 8 * DEFAULT_PPB;
  function automatic int last_col(input int cols);
    return cols - 1;
  endfunction
  function automatic int last_row(input int rows);
    return rows - 1;
  endfunction
endpackage

// File: rtl/pixel_unpacker_if.sv
// pixel_unpacker_if: valid/ready stream bundle (tvalid, tready, tdata[W-1:0], tuser); master drives, slave accepts
interface pixel_unpacker_if #(parameter int W = pixel_unpacker_pkg::BEAT_W);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tuser;
  modport master (output tvalid, tdata, tuser, input tready);
  modport slave (input tvalid, tdata, tuser, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: one-frame-per-ap_start burst-to-pixel unpacker; ports clk/reset, ap_start/idle/ready/done, s_axis (slave, beats, tuser=SOF), m_axis (master, Mono8 pixels), cnt_col/cnt_row, sticky sof_error; `define PIXEL_UNPACKER_RESYNC_EN to restart the frame on a mid-frame SOF beat
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int IN_ROWS          = 20,
  parameter int IN_COLS          = 20,
  parameter int PIXELS_PER_BURST = DEFAULT_PPB
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_ready,
  output logic                       ap_done,
  pixel_unpacker_if.slave            s_axis,
  pixel_unpacker_if.master           m_axis,
  output logic [$clog2(IN_COLS)-1:0] cnt_col,
  output logic [$clog2(IN_ROWS)-1:0] cnt_row,
  output logic                       sof_error
);
  localparam int W  = 8 * PIXELS_PER_BURST;
  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam int LW = PIXELS_PER_BURST > 1 ? $clog2(PIXELS_PER_BURST) : 1;
  localparam int NB = IN_ROWS * IN_COLS / PIXELS_PER_BURST;
  localparam int BW = $clog2(NB + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PIXELS_PER_BURST - 1);
  localparam logic [CW-1:0] LC = CW'(last_col(IN_COLS));
  localparam logic [RW-1:0] LR = RW'(last_row(IN_ROWS));
  state_t        r_state;
  logic [W-1:0]  r_buf;
  logic          r_buf_valid;
  logic [LW-1:0] r_lane;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [BW-1:0] r_nbeat;
  logic          r_sof_error;
  logic          w_last_lane;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_last_px;
  // r_nbeat counts beats loaded this frame; once the final beat is in, intake closes
  always_comb begin
    w_last_lane   = r_lane == LAST_LANE;
    s_axis.tready = r_state == WAIT_SOF ? 1'b1 :
                    r_state == STREAM   ? (r_nbeat != BW'(NB)) & (!r_buf_valid | (w_last_lane & m_axis.tready)) :
                                          1'b0;
    w_in_hs       = s_axis.tvalid & s_axis.tready;
    w_out_hs      = r_buf_valid & m_axis.tready;
    w_last_px     = w_out_hs & (r_col == LC) & (r_row == LR);
  end
  assign m_axis.tvalid = r_buf_valid;
  assign m_axis.tdata  = r_buf[8*r_lane +: 8];
  assign m_axis.tuser  = 1'b0;
  assign ap_idle       = r_state == IDLE;
  assign ap_ready      = ap_idle & ap_start;
  assign ap_done       = r_state == DONE;
  assign cnt_col       = r_col;
  assign cnt_row       = r_row;
  assign sof_error     = r_sof_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_lane      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_nbeat     <= '0;
      r_sof_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (ap_start) begin
          r_state     <= WAIT_SOF;
          r_sof_error <= 1'b0;
          r_lane      <= '0;
          r_col       <= '0;
          r_row       <= '0;
          r_nbeat     <= '0;
        end
        WAIT_SOF: if (w_in_hs && s_axis.tuser) begin
          r_buf       <= s_axis.tdata;
          r_buf_valid <= 1'b1;
          r_lane      <= '0;
          r_nbeat     <= BW'(1);
          r_state     <= STREAM;
        end
        STREAM: begin
          if (w_out_hs) begin
            r_lane      <= w_last_lane ? '0 : r_lane + 1'b1;
            r_buf_valid <= !w_last_lane;
            r_col       <= r_col == LC ? '0 : r_col + 1'b1;
            r_row       <= r_col != LC ? r_row : r_row == LR ? '0 : r_row + 1'b1;
          end
          // a new beat arriving alongside the last-lane handshake overrides the drain above
          if (w_in_hs) begin
            r_buf       <= s_axis.tdata;
            r_buf_valid <= 1'b1;
            r_lane      <= '0;
            r_nbeat     <= r_nbeat + 1'b1;
            if (s_axis.tuser) begin
              r_sof_error <= 1'b1;
`ifdef PIXEL_UNPACKER_RESYNC_EN
              r_col       <= '0;
              r_row       <= '0;
              r_nbeat     <= BW'(1);
`else
`endif
            end
          end
          if (w_last_px) begin
            r_state     <= DONE;
            r_buf_valid <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed self-checking bench for pixel_unpacker on a 4x4 frame with 4-pixel beats
module tb_pixel_unpacker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ap_start = 1'b0;
  logic       ap_idle, ap_ready, ap_done, sof_error;
  logic [1:0] cnt_col, cnt_row;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] beat_q[$];
  logic        sof_q[$];
  logic [7:0]  px_q[$];
  int          col_q[$];
  int          row_q[$];
  int          npx, ndone, nready, first_hs, last_hs, lc, lr;
  always #5 clk = ~clk;
  pixel_unpacker_if #(.W(32)) s_axis ();
  pixel_unpacker_if #(.W(8))  m_axis ();
  pixel_unpacker #(.IN_ROWS(4), .IN_COLS(4), .PIXELS_PER_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .cnt_col   (cnt_col),
    .cnt_row   (cnt_row),
    .sof_error (sof_error)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic add_beat(input logic [31:0] d, input logic s);
    beat_q.push_back(d);
    sof_q.push_back(s);
  endtask
  task automatic add_px(input logic [7:0] v, input int c, input int r);
    px_q.push_back(v);
    col_q.push_back(c);
    row_q.push_back(r);
  endtask
  // four beats of consecutive byte values starting at base, SOF on the first
  task automatic add_frame(input logic [7:0] base);
    logic [7:0] v;
    for (int b = 0; b < 4; b++) begin
      v = base + 8'(4 * b);
      add_beat({v + 8'd3, v + 8'd2, v + 8'd1, v}, b == 0);
    end
    for (int k = 0; k < 16; k++) add_px(base + 8'(k), k % 4, k / 4);
  endtask
  task automatic start();
    ap_start = 1'b1;
    @(negedge clk);
    chk("start_idle", ap_idle, 1);
    chk("start_ready", ap_ready, 1);
    @(posedge clk); #1;
    ap_start = 1'b0;
    chk("busy_not_idle", ap_idle, 0);
    chk("sof_error_cleared", sof_error, 0);
  endtask
  // drive queued beats, consume pixels against the expected queue until want_done ap_done pulses or stop_px pixels
  task automatic run(input int want_done, input int stop_px, input bit toggle, input int max_cyc);
    int         cyc = 0;
    bit         rdy = 1'b1;
    bit         stalled = 1'b0;
    logic [7:0] sd;
    logic [1:0] sc, sr;
    npx = 0; ndone = 0; nready = 0; first_hs = -1; last_hs = -10; lc = -1; lr = -1;
    while (ndone < want_done && !(stop_px > 0 && npx >= stop_px) && cyc < max_cyc) begin
      s_axis.tvalid = beat_q.size() > 0;
      s_axis.tdata  = beat_q.size() > 0 ? beat_q[0] : 32'h0;
      s_axis.tuser  = sof_q.size() > 0 ? sof_q[0] : 1'b0;
      m_axis.tready = toggle ? rdy : 1'b1;
      rdy = !rdy;
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", m_axis.tvalid, 1);
        chk("stall_tdata", m_axis.tdata, sd);
        chk("stall_col", cnt_col, sc);
        chk("stall_row", cnt_row, sr);
      end
      stalled = m_axis.tvalid && !m_axis.tready;
      sd = m_axis.tdata; sc = cnt_col; sr = cnt_row;
      chk("ready_only_in_idle", ap_ready, ap_idle & ap_start);
      if (ap_ready) nready++;
      if (s_axis.tvalid && s_axis.tready) begin
        void'(beat_q.pop_front());
        void'(sof_q.pop_front());
      end
      if (m_axis.tvalid && m_axis.tready) begin
        chk("pixel_expected", px_q.size() > 0, 1);
        if (px_q.size() > 0) begin
          chk("pixel", m_axis.tdata, px_q[0]);
          chk("col", cnt_col, col_q[0]);
          chk("row", cnt_row, row_q[0]);
          void'(px_q.pop_front());
          lc = col_q.pop_front();
          lr = row_q.pop_front();
        end
        npx++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (ap_done) begin
        ndone++;
        chk("done_latency", cyc, last_hs + 1);
        chk("done_last_pos", lr * 4 + lc, 15);
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    if (stop_px == 0) chk("done_count", ndone, want_done);
  endtask
  initial begin
    int seen;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 32'h0;
    s_axis.tuser  = 1'b0;
    m_axis.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_ready", ap_ready, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_mvalid", m_axis.tvalid, 0);
    chk("rst_sready", s_axis.tready, 0);
    chk("rst_col", cnt_col, 0);
    chk("rst_row", cnt_row, 0);
    chk("rst_sof_error", sof_error, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    // 1: plain 4x4 frame, both sides always ready
    add_frame(8'h00);
    start();
    run(1, 0, 1'b0, 200);
    chk("t1_npx", npx, 16);
    chk("t1_throughput", last_hs - first_hs, 15);
    chk("t1_idle_after", ap_idle, 1);
    chk("t1_sready_idle", s_axis.tready, 0);
    // 2: two junk beats without SOF ahead of the frame
    add_beat(32'hAAAAAAAA, 1'b0);
    add_beat(32'hBBBBBBBB, 1'b0);
    add_frame(8'h40);
    start();
    run(1, 0, 1'b0, 200);
    chk("t2_npx", npx, 16);
    chk("t2_beats_left", beat_q.size(), 0);
    // 3: downstream ready toggling every cycle
    add_frame(8'h10);
    start();
    run(1, 0, 1'b1, 400);
    chk("t3_npx", npx, 16);
    chk("t3_pixels_left", px_q.size(), 0);
    // 4: SOF on the third beat
    add_beat(32'h03020100, 1'b1);
    add_beat(32'h07060504, 1'b0);
    add_beat(32'h0B0A0908, 1'b1);
    add_beat(32'h0F0E0D0C, 1'b0);
    for (int k = 0; k < 8; k++) add_px(8'(k), k % 4, k / 4);
`ifdef PIXEL_UNPACKER_RESYNC_EN
    add_beat(32'h13121110, 1'b0);
    add_beat(32'h17161514, 1'b0);
    for (int k = 8; k < 24; k++) add_px(8'(k), (k - 8) % 4, (k - 8) / 4);
`else
    for (int k = 8; k < 16; k++) add_px(8'(k), k % 4, k / 4);
`endif
    start();
    run(1, 0, 1'b0, 200);
    chk("t4_sof_error", sof_error, 1);
`ifdef PIXEL_UNPACKER_RESYNC_EN
    chk("t4_npx", npx, 24);
`else
    chk("t4_npx", npx, 16);
`endif
    // 5: reset after seven pixels, then a clean frame
    add_frame(8'h20);
    start();
    run(1, 7, 1'b0, 200);
    chk("t5_npx_before_reset", npx, 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_idle", ap_idle, 1);
    chk("t5_mvalid", m_axis.tvalid, 0);
    chk("t5_col", cnt_col, 0);
    chk("t5_row", cnt_row, 0);
    chk("t5_sready", s_axis.tready, 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(ap_done);
    end
    chk("t5_no_done", seen, 0);
    @(posedge clk); #1;
    beat_q.delete(); sof_q.delete(); px_q.delete(); col_q.delete(); row_q.delete();
    add_frame(8'h60);
    start();
    run(1, 0, 1'b0, 200);
    chk("t5_clean_npx", npx, 16);
    // 6: ap_start held high across two back-to-back frames
    add_frame(8'h00);
    add_frame(8'h80);
    ap_start = 1'b1;
    run(2, 0, 1'b0, 400);
    ap_start = 1'b0;
    chk("t6_ready_pulses", nready, 2);
    chk("t6_npx", npx, 32);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
